// File: rtl/sd_adc_decimator.sv
// ----------------------------------------------------------------------------
// sd_adc_decimator
//
// Back end of a first-order sigma-delta converter built around the LVDS input
// comparator. The raw comparator output is synchronised into the hf_osc
// domain and driven straight back out as the 1-bit feedback. That pin is
// RC-filtered and returned to the comparator reference. The number of ones in
// the feedback stream over a 2^OSR_BITS-cycle window is delivered as one
// sample over a valid/ready handshake.
//
// Parameters
//   OSR_BITS       window length is 2^OSR_BITS cycles; also the sample width
//   SETTLE_CYCLES  loop run-in cycles before counting starts (1..65535)
//
// Ports
//   hf_osc        in   clock (6 MHz), all logic on the rising edge
//   rst           in   synchronous active-high reset
//   comp_in       in   raw comparator output, asynchronous to hf_osc
//   enable        in   run the converter while high
//   sample_ready  in   consumer accepts the current sample
//   fb_out        out  registered feedback bit for the RC DAC
//   sample        out  last completed window count (saturated)
//   sample_valid  out  sample holds an unconsumed value
//   overrun       out  sticky: a sample was overwritten before acceptance
//   busy          out  converter is not idle
// ----------------------------------------------------------------------------
module sd_adc_decimator #(
    parameter int OSR_BITS      = 8,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                hf_osc,
    input  logic                rst,
    input  logic                comp_in,
    input  logic                enable,
    input  logic                sample_ready,
    output logic                fb_out,
    output logic [OSR_BITS-1:0] sample,
    output logic                sample_valid,
    output logic                overrun,
    output logic                busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CONVERT = 2'd2;

    localparam logic [15:0]         SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [OSR_BITS-1:0] ALL_ONES    = '1;
    localparam logic [OSR_BITS-1:0] WIN_ONE     = OSR_BITS'(1);

    logic                comp_s1_q, comp_s1_d;
    logic                comp_s2_q, comp_s2_d;
    logic [1:0]          state_q, state_d;
    logic [15:0]         settle_cnt_q, settle_cnt_d;
    logic [OSR_BITS:0]   acc_q, acc_d;
    logic [OSR_BITS-1:0] win_cnt_q, win_cnt_d;
    logic                fb_q, fb_d;
    logic [OSR_BITS-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [OSR_BITS:0]   result;
    logic                win_end;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a combinational output unassigned (which would infer a latch).
        comp_s1_d    = comp_in;
        comp_s2_d    = comp_s1_q;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        acc_d        = acc_q;
        win_cnt_d    = win_cnt_q;
        sample_d     = sample_q;
        valid_d      = valid_q;
        overrun_d    = overrun_q;

        // The window total includes the feedback bit of the final cycle.
        result  = acc_q + {{OSR_BITS{1'b0}}, fb_q};
        win_end = (state_q == ST_CONVERT) && (win_cnt_q == ALL_ONES);

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = ST_CONVERT;
                    settle_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_CONVERT: begin
                // win_cnt wraps naturally at the window end.
                win_cnt_d = win_cnt_q + WIN_ONE;
                acc_d     = win_end ? '0 : result;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable abandons any partial window from any state.
        if (!enable) begin
            state_d      = ST_IDLE;
            settle_cnt_d = '0;
            acc_d        = '0;
            win_cnt_d    = '0;
        end

        // Feedback runs only while the loop is active and not being shut down.
        fb_d = (state_q != ST_IDLE) && enable ? comp_s2_q : 1'b0;

        // Handshake: acceptance clears valid; a window end (later in this
        // block) takes precedence and reloads it.
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        if (win_end) begin
            // Only the all-ones window reaches 2^OSR_BITS; clamp it.
            sample_d = result[OSR_BITS] ? ALL_ONES : result[OSR_BITS-1:0];
            valid_d  = 1'b1;
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hf_osc) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, whatever the order.
        if (rst) begin
            comp_s1_q    <= 1'b0;
            comp_s2_q    <= 1'b0;
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            acc_q        <= '0;
            win_cnt_q    <= '0;
            fb_q         <= 1'b0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            comp_s1_q    <= comp_s1_d;
            comp_s2_q    <= comp_s2_d;
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            acc_q        <= acc_d;
            win_cnt_q    <= win_cnt_d;
            fb_q         <= fb_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fb_out       = fb_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_adc_decimator.sv
// ----------------------------------------------------------------------------
// tb_sd_adc_decimator
//
// Directed bench for sd_adc_decimator with OSR_BITS=4, SETTLE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are read at that same point.
// In each scenario "edge k" is the edge just before enable is raised.
// ----------------------------------------------------------------------------
module tb_sd_adc_decimator;

    localparam int OSR_BITS      = 4;
    localparam int SETTLE_CYCLES = 4;

    logic                hf_osc;
    logic                rst;
    logic                comp_in;
    logic                enable;
    logic                sample_ready;
    logic                fb_out;
    logic [OSR_BITS-1:0] sample;
    logic                sample_valid;
    logic                overrun;
    logic                busy;

    int n_cmp = 0;
    int n_err = 0;

    // comp_in history: h1 is the value seen at the last edge, h3 three edges ago.
    logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
    logic toggle_mode = 1'b0;

    sd_adc_decimator #(
        .OSR_BITS      (OSR_BITS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .hf_osc       (hf_osc),
        .rst          (rst),
        .comp_in      (comp_in),
        .enable       (enable),
        .sample_ready (sample_ready),
        .fb_out       (fb_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial hf_osc = 1'b0;
    always #5 hf_osc = ~hf_osc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic pre;
        pre = comp_in;
        @(posedge hf_osc);
        #1;
        h3 = h2;
        h2 = h1;
        h1 = pre;
        if (toggle_mode) comp_in = ~comp_in;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset, let the synchroniser fill, then raise enable right after edge k.
    task automatic start(input logic c, input logic r);
        rst          = 1'b1;
        enable       = 1'b0;
        comp_in      = c;
        sample_ready = r;
        tick_n(2);
        rst = 1'b0;
        tick_n(3);
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;

        // ---------------- reset state ----------------
        rst = 1'b1; enable = 1'b1; comp_in = 1'b1; sample_ready = 1'b0;
        tick_n(3);
        check("rst_fb",      fb_out,       0);
        check("rst_sample",  sample,       0);
        check("rst_valid",   sample_valid, 0);
        check("rst_overrun", overrun,      0);
        check("rst_busy",    busy,         0);

        // ---------------- comp_in=1, ready=1: saturated samples ----------------
        start(1'b1, 1'b1);
        check("t1_busy_k", busy, 0);
        tick();
        check("t1_busy_k1", busy, 1);
        tick_n(19);
        check("t1_valid_k20", sample_valid, 0);
        tick();
        check("t1_valid_k21",  sample_valid, 1);
        check("t1_sample_k21", sample,       15);
        check("t1_fb_k21",     fb_out,       1);
        tick();
        check("t1_valid_k22", sample_valid, 0);
        tick_n(14);
        check("t1_valid_k36", sample_valid, 0);
        tick();
        check("t1_valid_k37",  sample_valid, 1);
        check("t1_sample_k37", sample,       15);
        check("t1_overrun",    overrun,      0);

        // ---------------- comp_in=0: zero samples, fb stays low ----------------
        start(1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 21; i++) begin
            tick();
            if (fb_out) cnt++;
        end
        check("t2_valid_k21",  sample_valid, 1);
        check("t2_sample_k21", sample,       0);
        tick_n(16);
        check("t2_valid_k37",  sample_valid, 1);
        check("t2_sample_k37", sample,       0);
        check("t2_fb_ones",    cnt,          0);

        // ---------------- comp_in toggling: half-scale ----------------
        toggle_mode = 1'b1;
        start(1'b0, 1'b1);
        tick();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fb_out !== h3) cnt++;
        end
        check("t3_fb_delay_errs", cnt,          0);
        check("t3_valid_k21",     sample_valid, 1);
        check("t3_sample_k21",    sample,       8);
        tick();
        check("t3_fb_follows", fb_out, h3);
        tick();
        check("t3_fb_follows2", fb_out, h3);
        tick_n(14);
        check("t3_sample_k37", sample, 8);
        check("t3_valid_k37",  sample_valid, 1);
        toggle_mode = 1'b0;

        // ---------------- overrun with ready held low ----------------
        start(1'b1, 1'b0);
        tick_n(21);
        check("t4_valid_k21",   sample_valid, 1);
        check("t4_overrun_k21", overrun,      0);
        tick_n(16);
        check("t4_valid_k37",   sample_valid, 1);
        check("t4_sample_k37",  sample,       15);
        check("t4_overrun_k37", overrun,      1);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        check("t4_valid_k38",   sample_valid, 0);
        check("t4_overrun_k38", overrun,      1);

        // ---------------- ready exactly on a window end ----------------
        start(1'b1, 1'b0);
        tick_n(21);
        check("t5_sample_k21", sample, 15);
        comp_in = 1'b0;   // only 3 ones reach the second window
        tick_n(15);
        check("t5_valid_k36", sample_valid, 1);
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        check("t5_valid_k37",   sample_valid, 1);
        check("t5_sample_k37",  sample,       3);
        check("t5_overrun_k37", overrun,      0);
        tick();
        check("t5_valid_k38", sample_valid, 1);

        // ---------------- enable dropped mid-window, re-enable, rst ----------------
        start(1'b1, 1'b1);
        tick_n(21);
        check("t6_valid_k21", sample_valid, 1);
        tick_n(6);
        enable = 1'b0;
        tick();
        check("t6_busy_off", busy,         0);
        check("t6_fb_off",   fb_out,       0);
        check("t6_valid_off", sample_valid, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (sample_valid) cnt++;
        end
        check("t6_no_partial", cnt, 0);
        enable = 1'b1;
        tick();
        check("t6_rebusy", busy, 1);
        tick_n(19);
        check("t6_revalid_k20", sample_valid, 0);
        tick();
        check("t6_revalid_k21", sample_valid, 1);
        check("t6_resample",    sample,       15);
        sample_ready = 1'b0;
        tick_n(16);
        check("t6_overrun_pre", overrun, 1);
        tick_n(3);
        rst = 1'b1;
        tick();
        check("t6_rst_fb",      fb_out,       0);
        check("t6_rst_sample",  sample,       0);
        check("t6_rst_valid",   sample_valid, 0);
        check("t6_rst_overrun", overrun,      0);
        check("t6_rst_busy",    busy,         0);
        rst    = 1'b0;
        enable = 1'b0;
        tick_n(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_adc_decimator.md
# sd_adc_decimator

First-order sigma-delta converter back end for the LVDS-input comparator. It synchronises the raw comparator output (SB_IO `D_IN_1`) into the `hf_osc` domain and drives it back out as the 1-bit feedback. That feedback pin is RC-filtered and returned to the comparator's reference input. The block counts feedback ones over a power-of-two window and delivers each count as a sample over a valid/ready handshake.

## Interface
- `OSR_BITS`, 8: window length = 2^OSR_BITS cycles; sample width.
- `SETTLE_CYCLES`, 64: cycles of loop run before counting starts; legal range 1..65535.
- `hf_osc`  in  1: clock, 6 MHz from SB_HFOSC. One clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `comp_in`  in  1: raw comparator output, asynchronous to `hf_osc`.
- `enable`  in  1: run converter while high.
- `sample_ready`  in  1: consumer accepts sample.
- `fb_out`  out  1: registered feedback bit; drives the SB_IO output for the RC DAC.
- `sample`  out  OSR_BITS: last completed window count.
- `sample_valid`  out  1: `sample` holds an unconsumed value.
- `overrun`  out  1: sticky flag; a sample was overwritten before it was accepted.
- `busy`  out  1: state is not IDLE.

## Operation
- Synchroniser: two flops `comp_s1`, `comp_s2` from `comp_in`. `fb_out <= comp_s2` while the state is SETTLE or CONVERT, else 0.
- State machine:
  - IDLE -> SETTLE when `enable`=1.
  - SETTLE: settle counter counts SETTLE_CYCLES cycles, then -> CONVERT. No accumulation.
  - CONVERT: each cycle, accumulator `acc` (OSR_BITS+1 bits) += `fb_out`. Window counter `win_cnt` (OSR_BITS bits) increments.
  - Any state -> IDLE on the next edge when `enable`=0. Going to IDLE clears `acc`, `win_cnt`, the settle counter and `fb_out`. `sample`, `sample_valid` and `overrun` are retained.
- Window end (CONVERT and `win_cnt` = all ones):
  - result = `acc` + `fb_out`.
  - If result = 2^OSR_BITS, saturate to 2^OSR_BITS-1.
  - `sample` <= result; `sample_valid` <= 1.
  - `acc` <= 0; `win_cnt` wraps to 0; conversion continues back to back.
- Handshake:
  - `sample_valid` falls on the edge after a cycle with `sample_valid`=1 and `sample_ready`=1.
  - If that cycle is also a window end, the new sample is loaded, `sample_valid` stays 1 and `overrun` is unchanged.
  - Window end with `sample_valid`=1 and `sample_ready`=0: `sample` is overwritten and `overrun` <= 1.
- `overrun` clears only on `rst`.
- `rst` has priority over everything. Reset values: `fb_out`=0, `sample`=0, `sample_valid`=0, `overrun`=0, `busy`=0, state IDLE, all counters and synchroniser flops 0.

## Timing
- `comp_in` to `fb_out`: 3 edges (2 sync + 1 output register).
- `enable` sampled high at edge k:
  - `busy`=1 from edge k+1.
  - CONVERT from edge k+1+SETTLE_CYCLES.
  - First `sample_valid` at edge k+1+SETTLE_CYCLES+2^OSR_BITS.
  - Subsequent samples every 2^OSR_BITS edges.
- Each window counts exactly 2^OSR_BITS consecutive `fb_out` values, sampled in CONVERT cycles only.
- `enable` low at edge j: IDLE and `busy`=0 at edge j+1. A partial window is discarded and produces no sample.
- `rst` mid-conversion: all outputs take their reset values at that edge. Operation restarts from IDLE.
- `sample_ready` is ignored while `sample_valid`=0.

## Test plan
- OSR_BITS=4, SETTLE_CYCLES=4, `comp_in`=1, `enable` rises at edge k, `sample_ready`=1 -> `busy` at k+1; `sample_valid` first at k+21 with `sample`=15 (saturated from 16); then every 16 edges.
- Same parameters, `comp_in`=0 -> `sample`=0 each window; `fb_out` stays 0.
- `comp_in` toggling every cycle -> `fb_out` alternates, delayed 3 edges; every `sample`=8.
- `comp_in`=1, `sample_ready`=0 for two windows -> after the second window `overrun`=1, `sample`=15, `sample_valid`=1. One ready cycle then clears `sample_valid`; `overrun` stays 1.
- `sample_ready`=1 exactly on a window-end cycle with a pending sample -> new sample loaded, `sample_valid` stays 1, `overrun`=0.
- `enable` dropped mid-window -> `busy`=0 next edge, no `sample_valid` pulse. Re-enable gives a full SETTLE and a full window. `rst` asserted mid-CONVERT with a pending sample -> all outputs 0 next edge.
